// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. It merges the main
// datapath (A) with a FIFO-buffered multiply/divide unit (B) and tracks pending B writes.
module regfile_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [4:0]    r_fifoRd   [DEPTH];
   logic [31:0]   r_fifoData [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starveCnt;
   logic [31:0]   r_busy;
   logic          r_rfWe;
   logic [4:0]    r_rfRd;
   logic [31:0]   r_rfData;

   logic          w_full;
   logic          w_nonEmpty;
   logic          w_forceB;
   logic          w_grantA;
   logic          w_grantB;
   logic          w_push;
   logic          w_pop;
   logic          w_winValid;
   logic [4:0]    w_winRd;
   logic [31:0]   w_winData;
   logic          w_commit;

   assign w_full     = (r_count == FULL_CNT);
   assign w_nonEmpty = (r_count != '0);

   // B is forced through when its FIFO is full or it has lost too many times in a row
   assign w_forceB   = w_nonEmpty && (w_full || (r_starveCnt == STARVE_LIM));
   assign w_grantA   = !w_forceB && a_valid;
   assign w_grantB   = w_forceB || (!a_valid && w_nonEmpty);
   assign w_push     = b_valid && !w_full;
   assign w_pop      = w_grantB;

   assign w_winValid = w_grantA || w_grantB;
   assign w_winRd    = w_grantB ? r_fifoRd[r_rdPtr]   : a_rd;
   assign w_winData  = w_grantB ? r_fifoData[r_rdPtr] : a_data;
   assign w_commit   = w_winValid && (w_winRd != 5'd0);

   assign a_ready = rst || !w_forceB;
   assign b_ready = rst || !w_full;
   assign rs_busy = !rst && (rs != 5'd0) && r_busy[rs];
   assign rt_busy = !rst && (rt != 5'd0) && r_busy[rt];

   assign rf_we   = r_rfWe;
   assign rf_rd   = r_rfRd;
   assign rf_data = r_rfData;

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_fifoRd[r_wrPtr]   <= b_rd;
         r_fifoData[r_wrPtr] <= b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_starveCnt <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Starvation only accumulates while B actually has something waiting
         if (w_pop || !w_nonEmpty) begin
            r_starveCnt <= '0;
         end else if (w_grantA && (r_starveCnt != STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rfWe   <= 1'b0;
         r_rfRd   <= 5'd0;
         r_rfData <= 32'd0;
      end else begin
         r_rfWe <= w_commit;
         if (w_commit) begin
            r_rfRd   <= w_winRd;
            r_rfData <= w_winData;
         end
      end
   end

   // The later set overrides a same-cycle clear of the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         if (w_pop) begin
            r_busy[w_winRd] <= 1'b0;
         end
         if (iss_valid && (iss_rd != 5'd0)) begin
            r_busy[iss_rd] <= 1'b1;
         end
      end
   end

endmodule
